// File: rtl/std_linear_sec_scrubber.sv
// rtl/std_linear_sec_scrubber.sv - background scrubber for linear SEC (Hamming) protected memory
// Purpose : walks addresses 0..DEPTH-1 of a single-port memory, decodes each K-bit codeword and
//           writes back a re-encoded word whenever a single-bit error was corrected.
// Codeword: bit i holds Hamming position i+1; parity bits sit at power-of-two positions, data
//           bits fill the remaining positions in ascending order. Syndrome = XOR of set positions.
// Ports   : i_clk/i_rst (async, active-high); i_enable starts/stops scrubbing;
//           o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata + i_mem_gnt form the request side;
//           i_mem_rvalid/i_mem_rdata return read data; o_busy, o_sweep_done, o_corr_count status;
//           i_corr_clr clears the counter; o_last_err_addr/o_err_seen diagnostic outputs.
// Option  : STD_LINEAR_SEC_SCRUB_LOG_EN enables o_last_err_addr/o_err_seen (tied 0 otherwise).

module std_linear_sec_encoder #(
    parameter int P = 9,
    parameter int N = (2 ** P) - 1 - P,
    parameter int K = N + P
) (
    input  logic [N-1:0] i_data,
    output logic [K-1:0] o_code
);
    logic [P-1:0] syn;

    always_comb begin
        int di;
        o_code = '0;
        syn    = '0;
        di     = 0;
        for (int pos = 1; pos <= K; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                o_code[pos-1] = i_data[di];
                if (i_data[di]) syn = syn ^ P'(pos);
                di++;
            end
        end
        // Each parity bit cancels its column so the full syndrome becomes zero.
        for (int j = 0; j < P; j++) o_code[(1 << j) - 1] = syn[j];
    end
endmodule

module std_linear_sec_decoder #(
    parameter int P = 9,
    parameter int N = (2 ** P) - 1 - P,
    parameter int K = N + P
) (
    input  logic [K-1:0] i_code,
    output logic [N-1:0] o_word,
    output logic         o_corrected
);
    logic [P-1:0] syn;
    logic [K-1:0] fixed;

    always_comb begin
        int di;
        syn = '0;
        for (int pos = 1; pos <= K; pos++)
            if (i_code[pos-1]) syn = syn ^ P'(pos);
        // Perfect code: every non-zero syndrome names exactly one bit position.
        fixed = i_code;
        if (syn != '0) fixed[int'(syn) - 1] = ~fixed[int'(syn) - 1];
        o_word = '0;
        di     = 0;
        for (int pos = 1; pos <= K; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                o_word[di] = fixed[pos-1];
                di++;
            end
        end
        o_corrected = (syn != '0);
    end
endmodule

module std_linear_sec_scrubber #(
    parameter int P        = 9,
    parameter int N        = (2 ** P) - 1 - P,
    parameter int K        = N + P,
    parameter int DEPTH    = 1024,
    parameter int AW       = $clog2(DEPTH),
    parameter int INTERVAL = 1024,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [AW-1:0]    o_mem_addr,
    output logic [K-1:0]     o_mem_wdata,
    input  logic             i_mem_gnt,
    input  logic             i_mem_rvalid,
    input  logic [K-1:0]     i_mem_rdata,
    output logic             o_busy,
    output logic             o_sweep_done,
    output logic [CNT_W-1:0] o_corr_count,
    input  logic             i_corr_clr,
    output logic [AW-1:0]    o_last_err_addr,
    output logic             o_err_seen
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_ADV
    } state_t;

    localparam logic [15:0]    TIMER_LOAD = 16'(INTERVAL);
    localparam logic [AW-1:0]  LAST_ADDR  = AW'(DEPTH - 1);

    state_t           state, state_nxt;
    logic [AW-1:0]    addr;
    logic [15:0]      timer;
    logic [N-1:0]     word_q;
    logic [CNT_W-1:0] corr_cnt;
    logic [N-1:0]     dec_word;
    logic             dec_corr;
    logic             rd_take;
    logic             corr_inc;

    std_linear_sec_decoder #(.P(P), .N(N), .K(K)) u_dec (
        .i_code      (i_mem_rdata),
        .o_word      (dec_word),
        .o_corrected (dec_corr)
    );

    std_linear_sec_encoder #(.P(P), .N(N), .K(K)) u_enc (
        .i_data (word_q),
        .o_code (o_mem_wdata)
    );

    assign rd_take  = (state == S_RD_WAIT) && i_mem_rvalid;
    assign corr_inc = rd_take && dec_corr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_sweep_done = 1'b0;
        case (state)
            S_IDLE:    if (i_enable) state_nxt = S_WAIT;
            // Leaving when the count reaches 0 (or was already 0) gives max(INTERVAL,1) wait cycles.
            S_WAIT:    if (timer <= 16'd1) state_nxt = S_RD_REQ;
            S_RD_REQ: begin
                o_mem_req = 1'b1;
                if (i_mem_gnt) state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: if (i_mem_rvalid) state_nxt = dec_corr ? S_WR_REQ : S_ADV;
            S_WR_REQ: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
                if (i_mem_gnt) state_nxt = S_ADV;
            end
            S_ADV: begin
                o_sweep_done = (addr == LAST_ADDR);
                state_nxt    = i_enable ? S_WAIT : S_IDLE;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr     <= '0;
            timer    <= '0;
            word_q   <= '0;
            corr_cnt <= '0;
        end else begin
            if (((state == S_IDLE) || (state == S_ADV)) && i_enable)
                timer <= TIMER_LOAD;
            else if (state == S_WAIT)
                timer <= (timer > 16'd1) ? timer - 16'd1 : 16'd0;

            if (state == S_ADV)
                addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;

            if (rd_take) word_q <= dec_word;

            // A clear that coincides with a correction leaves that correction counted.
            if (i_corr_clr)
                corr_cnt <= corr_inc ? CNT_W'(1) : '0;
            else if (corr_inc && (corr_cnt != '1))
                corr_cnt <= corr_cnt + 1'b1;
        end
    end

    assign o_mem_addr   = addr;
    assign o_busy       = (state != S_IDLE);
    assign o_corr_count = corr_cnt;

`ifdef STD_LINEAR_SEC_SCRUB_LOG_EN
    logic [AW-1:0] last_err_q;
    logic          err_seen_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_err_q <= '0;
            err_seen_q <= 1'b0;
        end else begin
            if (corr_inc) last_err_q <= addr;
            if (corr_inc)        err_seen_q <= 1'b1;
            else if (i_corr_clr) err_seen_q <= 1'b0;
        end
    end

    assign o_last_err_addr = last_err_q;
    assign o_err_seen      = err_seen_q;
`else
    assign o_last_err_addr = '0;
    assign o_err_seen      = 1'b0;
`endif
endmodule

// File: tb/tb_std_linear_sec_scrubber.sv
// tb/tb_std_linear_sec_scrubber.sv - scoreboard bench for std_linear_sec_scrubber
module tb_std_linear_sec_scrubber;
    localparam int P = 3, N = 4, K = 7, DEPTH = 4, AW = 2, INTERVAL = 2, CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             i_clk = 1'b0;
    logic             i_rst, i_enable, i_mem_gnt, i_mem_rvalid, i_corr_clr;
    logic [K-1:0]     i_mem_rdata;
    logic             o_mem_req, o_mem_we, o_busy, o_sweep_done, o_err_seen;
    logic [AW-1:0]    o_mem_addr, o_last_err_addr;
    logic [K-1:0]     o_mem_wdata;
    logic [CNT_W-1:0] o_corr_count;

    std_linear_sec_scrubber #(.P(P), .DEPTH(DEPTH), .INTERVAL(INTERVAL), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata(i_mem_rdata), .o_busy(o_busy), .o_sweep_done(o_sweep_done),
        .o_corr_count(o_corr_count), .i_corr_clr(i_corr_clr),
        .o_last_err_addr(o_last_err_addr), .o_err_seen(o_err_seen)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [K-1:0]  wdata;
        int            cnt;
    } acc_t;

    acc_t         exp_q[$];
    logic [K-1:0] valid_cw[$];
    logic [K-1:0] golden[DEPTH];
    logic [K-1:0] mem[DEPTH];
    int           checks = 0, errors = 0;
    int           model_cnt = 0, sweep_pulses = 0, withhold = 0;
    bit           gnt_block_wr = 0;
    logic         cap_we;
    logic [AW-1:0] cap_addr;
    logic [K-1:0] cap_wdata;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Valid codeword: XOR of the (1-based) positions of all set bits is zero.
    function automatic bit is_valid(input logic [K-1:0] w);
        int s = 0;
        for (int i = 0; i < K; i++) if (w[i]) s = s ^ (i + 1);
        return s == 0;
    endfunction

    task automatic push_sweep(input int first, input int last);
        acc_t e;
        for (int a = first; a <= last; a++) begin
            e.we = 1'b0; e.addr = AW'(a); e.wdata = '0; e.cnt = 0;
            exp_q.push_back(e);
            if (mem[a] != golden[a]) begin
                if (model_cnt < CNT_MAX) model_cnt++;
                e.we = 1'b1; e.wdata = golden[a]; e.cnt = model_cnt;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic corrupt(input int a, input int bitpos);
        logic [K-1:0] f;
        f = '0;
        f[bitpos] = 1'b1;
        mem[a] = golden[a] ^ f;
    endtask

    task automatic wait_sweep_done(input string name);
        int n = 0;
        while (!o_sweep_done && n < 300) begin @(negedge i_clk); n++; end
        if (!o_sweep_done) check({name, "_timeout"}, 32'd0, 32'd1);
        i_enable = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (o_busy && n < 300) begin @(negedge i_clk); n++; end
        check({name, "_idle"}, o_busy, 1'b0);
    endtask

    task automatic check_clean(input string name);
        for (int a = 0; a < DEPTH; a++) check(name, mem[a], golden[a]);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Memory model: grants at random, returns read data 1..3 cycles after a read grant.
    initial begin
        bit rd_pend = 0;
        int rd_cnt = 0;
        logic [AW-1:0] rd_addr = '0;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        forever begin
            @(posedge i_clk); #1;
            i_mem_rvalid = 1'b0;
            if (i_mem_gnt) begin
                if (cap_we) mem[cap_addr] = cap_wdata;
                else begin rd_pend = 1; rd_addr = cap_addr; rd_cnt = $urandom_range(0, 2); end
            end
            i_mem_gnt = 1'b0;
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    i_mem_rvalid = 1'b1; i_mem_rdata = mem[rd_addr]; rd_pend = 0;
                end else rd_cnt--;
            end
            if (o_mem_req && !(gnt_block_wr && o_mem_we)) begin
                if (withhold > 0) withhold--;
                else if ($urandom_range(0, 3) != 0) begin
                    i_mem_gnt = 1'b1;
                    cap_we = o_mem_we; cap_addr = o_mem_addr; cap_wdata = o_mem_wdata;
                end
            end
        end
    end

    // Monitor: every accepted access is popped from the scoreboard and compared.
    initial begin
        acc_t e;
        forever begin
            @(negedge i_clk);
            if (o_sweep_done) sweep_pulses++;
            if (o_mem_req && i_mem_gnt) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_access we %0b addr %0d", o_mem_we, o_mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_we", o_mem_we, e.we);
                    check("acc_addr", o_mem_addr, e.addr);
                    if (e.we) begin
                        check("acc_wdata", o_mem_wdata, e.wdata);
                        check("acc_corr_count", o_corr_count, e.cnt);
`ifdef STD_LINEAR_SEC_SCRUB_LOG_EN
                        check("acc_last_err_addr", o_last_err_addr, e.addr);
`endif
                    end
                end
            end
        end
    end

    initial begin
        int n;
        for (int w = 0; w < (1 << K); w++) if (is_valid(K'(w))) valid_cw.push_back(K'(w));
        for (int a = 0; a < DEPTH; a++) begin
            golden[a] = valid_cw[$urandom_range(1, valid_cw.size() - 1)];
            mem[a] = golden[a];
        end
        i_rst = 1'b1; i_enable = 1'b0; i_corr_clr = 1'b0;
        repeat (3) @(negedge i_clk);
        check("valid_cw_count", valid_cw.size(), 16);
        check("rst_req", o_mem_req, 1'b0);
        check("rst_we", o_mem_we, 1'b0);
        check("rst_addr", o_mem_addr, 0);
        check("rst_wdata", o_mem_wdata, 0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_sweep_done", o_sweep_done, 1'b0);
        check("rst_count", o_corr_count, 0);
        check("rst_last_err", o_last_err_addr, 0);
        check("rst_err_seen", o_err_seen, 1'b0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Clean sweep with a spurious rvalid while waiting.
        sweep_pulses = 0;
        push_sweep(0, DEPTH - 1);
        i_enable = 1'b1;
        @(negedge i_clk);
        check("wait_busy", o_busy, 1'b1);
        check("wait_no_req", o_mem_req, 1'b0);
        i_mem_rvalid = 1'b1; i_mem_rdata = golden[0] ^ 7'h01;
        wait_sweep_done("sweep1");
        wait_idle("sweep1");
        check("sweep1_pulses", sweep_pulses, 1);
        check("sweep1_count", o_corr_count, 0);
        check_clean("sweep1_mem");

        // Bit 5 at address 2, with the first grant withheld for 10 cycles.
        corrupt(2, 5);
        push_sweep(0, DEPTH - 1);
        withhold = 10;
        i_enable = 1'b1;
        n = 0;
        while (!o_mem_req && n < 50) begin @(negedge i_clk); n++; end
        check("hold_req_seen", o_mem_req, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            check("hold_req", o_mem_req, 1'b1);
            check("hold_addr", o_mem_addr, 0);
            check("hold_we", o_mem_we, 1'b0);
        end
        wait_sweep_done("sweep2");
        wait_idle("sweep2");
        check("sweep2_count", o_corr_count, 1);
`ifdef STD_LINEAR_SEC_SCRUB_LOG_EN
        check("sweep2_last_err", o_last_err_addr, 2);
        check("sweep2_err_seen", o_err_seen, 1'b1);
`else
        check("sweep2_last_err_tied", o_last_err_addr, 0);
        check("sweep2_err_seen_tied", o_err_seen, 1'b0);
`endif
        check_clean("sweep2_mem");

        // Enable dropped in RD_WAIT at address 1; resume at address 2.
        corrupt(1, $urandom_range(0, K - 1));
        push_sweep(0, 1);
        i_enable = 1'b1;
        n = 0;
        while (!(o_mem_req && i_mem_gnt && !o_mem_we && o_mem_addr == 1) && n < 100) begin
            @(negedge i_clk); n++;
        end
        check("rdwait_addr1_grant", o_mem_addr, 1);
        @(negedge i_clk);
        i_enable = 1'b0;
        check("rdwait_busy", o_busy, 1'b1);
        check("rdwait_no_req", o_mem_req, 1'b0);
        wait_idle("stop");
        check("stop_queue_empty", exp_q.size(), 0);
        check("stop_addr", o_mem_addr, 2);
        check("stop_count", o_corr_count, model_cnt);
        push_sweep(2, DEPTH - 1);
        i_enable = 1'b1;
        wait_sweep_done("resume");
        wait_idle("resume");
        check_clean("resume_mem");

        // Clear alone, then saturation over four corrupted words.
        i_corr_clr = 1'b1;
        @(negedge i_clk);
        i_corr_clr = 1'b0;
        check("clr_count", o_corr_count, 0);
`ifdef STD_LINEAR_SEC_SCRUB_LOG_EN
        check("clr_err_seen", o_err_seen, 1'b0);
`endif
        model_cnt = 0;
        for (int a = 0; a < DEPTH; a++) corrupt(a, $urandom_range(0, K - 1));
        push_sweep(0, DEPTH - 1);
        i_enable = 1'b1;
        wait_sweep_done("sat");
        wait_idle("sat");
        check("sat_count", o_corr_count, CNT_MAX);
        check_clean("sat_mem");

        // Clear coinciding with a correction leaves the count at 1.
        corrupt(0, $urandom_range(0, K - 1));
        push_sweep(0, 0);
        exp_q[exp_q.size() - 1].cnt = 1;
        model_cnt = 1;
        i_enable = 1'b1;
        n = 0;
        while (!(i_mem_rvalid && o_busy && !o_mem_req) && n < 100) begin @(negedge i_clk); n++; end
        i_corr_clr = 1'b1;
        @(negedge i_clk);
        i_corr_clr = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge i_clk); n++; end
        i_enable = 1'b0;
        wait_idle("clrinc");
        check("clrinc_count", o_corr_count, 1);
        check("clrinc_addr", o_mem_addr, 1);
        check_clean("clrinc_mem");

        // Reset while the write-back request is pending.
        corrupt(1, $urandom_range(0, K - 1));
        push_sweep(1, 1);
        gnt_block_wr = 1;
        i_enable = 1'b1;
        n = 0;
        while (!(o_mem_req && o_mem_we) && n < 100) begin @(negedge i_clk); n++; end
        check("wrreq_seen", o_mem_we, 1'b1);
        i_rst = 1'b1;
        #1;
        check("arst_req", o_mem_req, 1'b0);
        check("arst_we", o_mem_we, 1'b0);
        check("arst_addr", o_mem_addr, 0);
        check("arst_wdata", o_mem_wdata, 0);
        check("arst_busy", o_busy, 1'b0);
        check("arst_count", o_corr_count, 0);
        check("arst_last_err", o_last_err_addr, 0);
        check("arst_err_seen", o_err_seen, 1'b0);
        exp_q.delete();
        model_cnt = 0;
        gnt_block_wr = 0;
        i_enable = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        push_sweep(0, DEPTH - 1);
        i_enable = 1'b1;
        wait_sweep_done("post_rst");
        wait_idle("post_rst");
        check("post_rst_count", o_corr_count, 1);
`ifdef STD_LINEAR_SEC_SCRUB_LOG_EN
        check("post_rst_last_err", o_last_err_addr, 1);
        check("post_rst_err_seen", o_err_seen, 1'b1);
`endif
        check_clean("post_rst_mem");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
